// File: rtl/snn_pkg.sv
// -----------------------------------------------------------------------------
// snn_pkg
// Shared definitions for the spiking activation array:
//   - reset_mode encodings (RESET_ZERO, RESET_SUBTRACT)
//   - sat_signed(): clamps a wide signed value into a signed range of a
//     given width. Callers sign-extend into SAT_W bits and cast the
//     result back down to their own width.
// -----------------------------------------------------------------------------
package snn_pkg;

  localparam logic RESET_ZERO     = 1'b0;
  localparam logic RESET_SUBTRACT = 1'b1;

  // Working width of the saturation helper; must exceed any caller width.
  localparam int SAT_W = 64;

  function automatic logic signed [SAT_W-1:0] sat_signed(
    input logic signed [SAT_W-1:0] value,
    input int unsigned             width
  );
    logic signed [SAT_W-1:0] lim_hi;
    logic signed [SAT_W-1:0] lim_lo;
    lim_hi = (64'sd1 <<< (width - 1)) - 64'sd1;
    lim_lo = -lim_hi - 64'sd1;
    if (value > lim_hi) begin
      sat_signed = lim_hi;
    end else if (value < lim_lo) begin
      sat_signed = lim_lo;
    end else begin
      sat_signed = value;
    end
  endfunction

endpackage

// File: rtl/lif_channel.sv
// -----------------------------------------------------------------------------
// lif_channel
// One leaky integrate-and-fire neuron with refractory period and a
// saturating spike counter.
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   in_valid           in_data is valid this cycle
//   in_data            signed increment for this channel
//   threshold, leak    signed firing threshold and per-input leak
//   reset_mode         RESET_ZERO / RESET_SUBTRACT post-spike behaviour
//   clear_count        synchronous counter clear (a same-cycle spike still counts)
//   spike              registered spike flag for the accepted input
//   potential          current membrane potential
//   count              accumulated spike count (saturating)
// -----------------------------------------------------------------------------
module lif_channel
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int COUNT_WIDTH       = 8,
  parameter int REFRACTORY_CYCLES = 2
) (
  input  logic                          clk,
  input  logic                          rstn,
  input  logic                          in_valid,
  input  logic signed [DATA_WIDTH-1:0]  in_data,
  input  logic signed [DATA_WIDTH-1:0]  threshold,
  input  logic signed [DATA_WIDTH-1:0]  leak,
  input  logic                          reset_mode,
  input  logic                          clear_count,
  output logic                          spike,
  output logic signed [DATA_WIDTH-1:0]  potential,
  output logic [COUNT_WIDTH-1:0]        count
);

  // Two guard bits: V + in - leak spans at most three full-range operands.
  localparam int EXT_W = DATA_WIDTH + 2;
  localparam int REF_W = (REFRACTORY_CYCLES > 0) ? $clog2(REFRACTORY_CYCLES + 1) : 1;

  logic signed [DATA_WIDTH-1:0] r_v;
  logic [REF_W-1:0]             r_ref;
  logic [COUNT_WIDTH-1:0]       r_count;
  logic                         r_spike;

  logic signed [EXT_W-1:0]      w_sum;
  logic signed [EXT_W-1:0]      w_excess;
  logic signed [DATA_WIDTH-1:0] w_v_next;
  logic signed [DATA_WIDTH-1:0] w_v_sub;
  logic                         w_ref_idle;
  logic                         w_accept;
  logic                         w_fire;

  assign w_sum      = EXT_W'(r_v) + EXT_W'(in_data) - EXT_W'(leak);
  assign w_v_next   = DATA_WIDTH'(sat_signed(SAT_W'(w_sum), DATA_WIDTH));
  // After a spike the excess is non-negative but may exceed the positive range.
  assign w_excess   = EXT_W'(w_v_next) - EXT_W'(threshold);
  assign w_v_sub    = DATA_WIDTH'(sat_signed(SAT_W'(w_excess), DATA_WIDTH));
  assign w_ref_idle = (r_ref == '0);
  assign w_accept   = in_valid && w_ref_idle;
  assign w_fire     = w_accept && (w_v_next >= threshold);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_v     <= '0;
      r_ref   <= '0;
      r_count <= '0;
      r_spike <= 1'b0;
    end else begin
      r_spike <= w_fire;

      if (w_accept) begin
        if (!w_fire) begin
          r_v <= w_v_next;
        end else if (reset_mode == RESET_SUBTRACT) begin
          r_v <= w_v_sub;
        end else begin
          r_v <= '0;
        end
      end

      if (in_valid) begin
        if (!w_ref_idle) begin
          r_ref <= r_ref - REF_W'(1);
        end else if (w_fire) begin
          r_ref <= REF_W'(REFRACTORY_CYCLES);
        end
      end

      // Clear wins over the stored value but never drops this cycle's spike.
      if (clear_count) begin
        r_count <= COUNT_WIDTH'(w_fire);
      end else if (w_fire && (r_count != '1)) begin
        r_count <= r_count + COUNT_WIDTH'(1);
      end
    end
  end

  assign spike     = r_spike;
  assign potential = r_v;
  assign count     = r_count;

endmodule

// File: rtl/spiking_activation_array.sv
// -----------------------------------------------------------------------------
// spiking_activation_array
// NUM_CHANNELS independent LIF neurons sharing threshold, leak and mode.
// Ports:
//   clk, rstn                 clock, asynchronous active-low reset
//   in_valid                  channel_input valid this cycle
//   channel_input             packed signed increments, channel i at [i*DW +: DW]
//   threshold, leak           shared signed threshold and leak
//   reset_mode                0 reset-to-zero, 1 reset-by-subtraction
//   reset_accumulated_spikes  synchronous clear of all spike counters
//   out_valid                 spike_vector valid (one cycle after in_valid)
//   spike_vector              per-channel spike flags
//   accumulated_spikes        packed per-channel spike counts
// -----------------------------------------------------------------------------
module spiking_activation_array
  import snn_pkg::*;
#(
  parameter int DATA_WIDTH        = 16,
  parameter int NUM_CHANNELS      = 4,
  parameter int COUNT_WIDTH       = 8,
  parameter int REFRACTORY_CYCLES = 2
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                in_valid,
  input  logic [NUM_CHANNELS*DATA_WIDTH-1:0]  channel_input,
  input  logic signed [DATA_WIDTH-1:0]        threshold,
  input  logic signed [DATA_WIDTH-1:0]        leak,
  input  logic                                reset_mode,
  input  logic                                reset_accumulated_spikes,
  output logic                                out_valid,
  output logic [NUM_CHANNELS-1:0]             spike_vector,
  output logic [NUM_CHANNELS*COUNT_WIDTH-1:0] accumulated_spikes
);

  logic r_out_valid;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
    end
  end

  assign out_valid = r_out_valid;

  for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
    logic signed [DATA_WIDTH-1:0] w_potential;

    lif_channel #(
      .DATA_WIDTH        (DATA_WIDTH),
      .COUNT_WIDTH       (COUNT_WIDTH),
      .REFRACTORY_CYCLES (REFRACTORY_CYCLES)
    ) u_lif (
      .clk         (clk),
      .rstn        (rstn),
      .in_valid    (in_valid),
      .in_data     (channel_input[gi*DATA_WIDTH +: DATA_WIDTH]),
      .threshold   (threshold),
      .leak        (leak),
      .reset_mode  (reset_mode),
      .clear_count (reset_accumulated_spikes),
      .spike       (spike_vector[gi]),
      .potential   (w_potential),
      .count       (accumulated_spikes[gi*COUNT_WIDTH +: COUNT_WIDTH])
    );
  end

endmodule

// File: doc/spiking_activation_array.md
SPIKING_ACTIVATION_ARRAY -- requirements
Module: spiking_activation_array

Interface
REQ-001 Parameter DATA_WIDTH, default 16, signed width of potential, threshold, leak and channel inputs.
REQ-002 Parameter NUM_CHANNELS, default 4, number of independent neuron channels.
REQ-003 Parameter COUNT_WIDTH, default 8, unsigned width of each accumulated-spike counter.
REQ-004 Parameter REFRACTORY_CYCLES, default 2, number of accepted inputs ignored after a spike (0 disables).
REQ-005 Port clk input 1: the only clock; all state updates on its rising edge.
REQ-006 Port rstn input 1: reset, asynchronous and active-low.
REQ-007 Port in_valid input 1: channel_input is valid this cycle.
REQ-008 Port channel_input input NUM_CHANNELS*DATA_WIDTH: signed per-channel increments; channel i at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port threshold input DATA_WIDTH: signed firing threshold shared by all channels.
REQ-010 Port leak input DATA_WIDTH: signed amount subtracted from every potential on each accepted input.
REQ-011 Port reset_mode input 1: 0 = reset-to-zero, 1 = reset-by-subtraction.
REQ-012 Port reset_accumulated_spikes input 1: synchronous clear of all spike counters.
REQ-013 Port out_valid output 1: spike_vector is valid this cycle.
REQ-014 Port spike_vector output NUM_CHANNELS: per-channel spike flags for the accepted input.
REQ-015 Port accumulated_spikes output NUM_CHANNELS*COUNT_WIDTH: per-channel spike counts, same packing as REQ-008.

Function
REQ-016 Each channel holds a signed DATA_WIDTH membrane potential V, a refractory counter R and a spike counter C.
REQ-017 On in_valid with R==0: V_next = sat(V + input - leak), computed at DATA_WIDTH+2 bits and saturated to the signed DATA_WIDTH range.
REQ-018 Spike when V_next >= threshold (signed compare); the stored V is then 0 (mode 0) or sat(V_next - threshold) (mode 1); otherwise it is V_next.
REQ-019 On spike R loads REFRACTORY_CYCLES; on in_valid with R>0, V is unchanged, no spike, and R decrements by 1.
REQ-020 With in_valid low, V, R and C hold and spike_vector is all zero.
REQ-021 Latency is 1 cycle: out_valid and spike_vector register in_valid and the spike decisions of the same edge.
REQ-022 On spike, C increments and saturates at 2^COUNT_WIDTH-1 (no wrap).
REQ-023 reset_accumulated_spikes takes priority over the stored count: C_next = spike bit of that cycle (0 or 1), with no clear-then-lost spike.
REQ-024 reset_accumulated_spikes affects C only, not V or R.
REQ-025 threshold, leak and reset_mode are sampled on every accepted input; changes apply from the next accepted input.

Reset
REQ-026 rstn low asynchronously forces every V, R and C to 0, and forces out_valid and spike_vector to 0.
REQ-027 Reset mid-operation discards all in-flight state; the first in_valid after release is processed as from the zero state.

Structure
REQ-028 Shared package snn_pkg holds the reset_mode encoding constants (RESET_ZERO=0, RESET_SUBTRACT=1) and the signed-saturation function.
REQ-029 One sub-module lif_channel implements REQ-016..REQ-024 for a single channel; the top instantiates NUM_CHANNELS copies with a generate loop.
REQ-030 The top registers out_valid and packs the per-channel outputs; it contains no arithmetic.

Verification
REQ-031 Setup: threshold=10, leak=0, mode 0, REFRACTORY_CYCLES=0. Stimulus: inputs 4,4,4 on channel 0. Required: spike on the 3rd input only, one cycle later; V=0; C=1.
REQ-032 Setup: mode 1, threshold=10. Stimulus: input 25. Required: spike; V=15. Stimulus: next input 0. Required: spike; V=5; C=2.
REQ-033 Setup: REFRACTORY_CYCLES=2, threshold=5. Stimulus: inputs 5,5,5,5. Required: spike pattern 1,0,0,1.
REQ-034 Setup: DATA_WIDTH=16. Stimulus: input 32767 twice with threshold=32767, mode 1. Required: no overflow wrap; V saturates to 32767 before the compare; spike every input.
REQ-035 Setup: COUNT_WIDTH=2. Stimulus: force 5 spikes. Required: C stays at 3. Stimulus: reset_accumulated_spikes in the same cycle as a spike. Required: C=1.
REQ-036 Stimulus: assert rstn low between two valid inputs. Required: all outputs 0 immediately; the following input accumulates from V=0.
